// File: rtl/text_term_pkg.sv
// rtl/text_term_pkg.sv - shared constants, state enum and address helper for the text terminal
package text_term_pkg;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int ROW_W = 5;
    localparam int COL_W = 7;

    localparam logic [7:0] BLANK    = 8'h20;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_FF = 8'h0C;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLR_LINE,
        ST_CLR_ALL
    } term_state_e;

    // Text buffer address is the physical row in the high bits, column in the low bits.
    function automatic logic [ROW_W+COL_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                         input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/term_row_mod.sv
// rtl/term_row_mod.sv - (base + offset) mod ROWS row adder for write and display addressing
module term_row_mod
    import text_term_pkg::*;
(
    input  logic [ROW_W-1:0] base_i,
    input  logic [ROW_W-1:0] off_i,
    output logic [ROW_W-1:0] phys_o
);

    // One extra bit keeps the carry so the compare sees the true sum; ROWS is not a power of two.
    logic [ROW_W:0] raw;

    assign raw    = {1'b0, base_i} + {1'b0, off_i};
    assign phys_o = (raw >= (ROW_W+1)'(ROWS)) ? ROW_W'(raw - (ROW_W+1)'(ROWS))
                                              : raw[ROW_W-1:0];

endmodule

// File: rtl/text_term_ctrl.sv
// rtl/text_term_ctrl.sv - keyboard-to-text-buffer terminal controller with offset scrolling
module text_term_ctrl
    import text_term_pkg::*;
(
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     key_valid,
    input  logic [7:0]               key_ascii,
    output logic                     key_ready,
    output logic                     wr_en,
    output logic [ROW_W+COL_W-1:0]   wr_addr,
    output logic [7:0]               wr_data,
    output logic [ROW_W-1:0]         top_row,
    output logic [ROW_W-1:0]         cur_row,
    output logic [COL_W-1:0]         cur_col
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    term_state_e        state_q, state_d;
    logic [ROW_W-1:0]   cur_row_q, cur_row_d;
    logic [COL_W-1:0]   cur_col_q, cur_col_d;
    logic [ROW_W-1:0]   top_row_q, top_row_d;
    logic [ROW_W-1:0]   clr_row_q, clr_row_d;
    logic [COL_W-1:0]   clr_col_q, clr_col_d;
    logic [7:0]         put_data_q, put_data_d;
    logic               put_adv_q, put_adv_d;
    // Low for the first cycle after reset so the reset cycle itself issues no write.
    logic               arm_q;
    logic               do_nl;
    logic [ROW_W-1:0]   phys_cur, phys_one;

    term_row_mod u_phys_cur (.base_i(top_row_q), .off_i(cur_row_q),     .phys_o(phys_cur));
    term_row_mod u_phys_one (.base_i(top_row_q), .off_i(ROW_W'(1)),     .phys_o(phys_one));

    // State and datapath registers; reset lands in a full-screen clear.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q    <= ST_CLR_ALL;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            top_row_q  <= '0;
            clr_row_q  <= '0;
            clr_col_q  <= '0;
            put_data_q <= BLANK;
            put_adv_q  <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            top_row_q  <= top_row_d;
            clr_row_q  <= clr_row_d;
            clr_col_q  <= clr_col_d;
            put_data_q <= put_data_d;
            put_adv_q  <= put_adv_d;
            arm_q      <= 1'b1;
        end
    end

    // Next state: key decode, cursor movement, newline/scroll and clear sweeps.
    always_comb begin
        state_d    = state_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        top_row_d  = top_row_q;
        clr_row_d  = clr_row_q;
        clr_col_d  = clr_col_q;
        put_data_d = put_data_q;
        put_adv_d  = put_adv_q;
        do_nl      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) begin
                        put_data_d = key_ascii;
                        put_adv_d  = 1'b1;
                        state_d    = ST_PUT;
                    end else if (key_ascii == ASCII_CR || key_ascii == ASCII_LF) begin
                        do_nl = 1'b1;
                    end else if (key_ascii == ASCII_BS) begin
                        // Blank is written at the new position, so the cursor moves first.
                        if (cur_col_q != '0) begin
                            cur_col_d  = cur_col_q - 1'b1;
                            put_data_d = BLANK;
                            put_adv_d  = 1'b0;
                            state_d    = ST_PUT;
                        end else if (cur_row_q != '0) begin
                            cur_row_d  = cur_row_q - 1'b1;
                            cur_col_d  = LAST_COL;
                            put_data_d = BLANK;
                            put_adv_d  = 1'b0;
                            state_d    = ST_PUT;
                        end
                    end else if (key_ascii == ASCII_FF) begin
                        clr_row_d = '0;
                        clr_col_d = '0;
                        state_d   = ST_CLR_ALL;
                    end
                end
            end
            ST_PUT: begin
                state_d = ST_IDLE;
                if (put_adv_q) begin
                    if (cur_col_q != LAST_COL) begin
                        cur_col_d = cur_col_q + 1'b1;
                    end else begin
                        cur_col_d = '0;
                        do_nl     = 1'b1;
                    end
                end
            end
            ST_CLR_LINE: begin
                if (clr_col_q == LAST_COL) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_col_d = clr_col_q + 1'b1;
                end
            end
            ST_CLR_ALL: begin
                if (arm_q) begin
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        if (clr_row_q == LAST_ROW) begin
                            top_row_d = '0;
                            cur_row_d = '0;
                            cur_col_d = '0;
                            state_d   = ST_IDLE;
                        end else begin
                            clr_row_d = clr_row_q + 1'b1;
                        end
                    end else begin
                        clr_col_d = clr_col_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // At the bottom row the screen scrolls: the old top row becomes the new bottom and is blanked.
        if (do_nl) begin
            cur_col_d = '0;
            if (cur_row_q != LAST_ROW) begin
                cur_row_d = cur_row_q + 1'b1;
                state_d   = ST_IDLE;
            end else begin
                top_row_d = phys_one;
                clr_row_d = top_row_q;
                clr_col_d = '0;
                state_d   = ST_CLR_LINE;
            end
        end
    end

    // Outputs: handshake and text buffer write port decoded from the current state.
    always_comb begin
        key_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = BLANK;
        case (state_q)
            ST_IDLE: key_ready = 1'b1;
            ST_PUT: begin
                wr_en   = 1'b1;
                wr_addr = pack_addr(phys_cur, cur_col_q);
                wr_data = put_data_q;
            end
            ST_CLR_LINE: begin
                wr_en   = 1'b1;
                wr_addr = pack_addr(clr_row_q, clr_col_q);
            end
            ST_CLR_ALL: begin
                wr_en   = arm_q;
                wr_addr = pack_addr(clr_row_q, clr_col_q);
            end
            default: ;
        endcase
    end

    assign top_row = top_row_q;
    assign cur_row = cur_row_q;
    assign cur_col = cur_col_q;

endmodule

// File: doc/text_term_ctrl.md
Name: text_term_ctrl

Overview:
- Terminal controller between the keyboard ASCII path and the character video memory (the 4096×8 text buffer addressed as {row[4:0], col[6:0]}).
- Accepts one ASCII code per handshake and writes it at the cursor.
- Handles newline, backspace and clear-screen.
- Scrolls by rotating a top-row offset and blanking the recycled row, so no memory copy is needed. The VGA text path adds the offset when fetching characters.

Parameters:
- COLS, 70, characters per row (valid col 0..COLS-1, col field 7 bits)
- ROWS, 30, character rows (valid row 0..ROWS-1, row field 5 bits)
- BLANK, 8'h20, code written to cleared cells

Ports:
- clk  in  1  system clock
- clrn  in  1  synchronous active-low reset
- key_valid  in  1  key_ascii holds a new character
- key_ascii  in  8  ASCII code from the scancode→ASCII table
- key_ready  out  1  controller can accept a character this cycle
- wr_en  out  1  write strobe to text buffer
- wr_addr  out  12  {phys_row[4:0], col[6:0]}
- wr_data  out  8  character to write
- top_row  out  5  physical row shown as screen row 0 (display reads phys = (scr_row + top_row) mod ROWS)
- cur_row  out  5  logical cursor row (0 = top of screen)
- cur_col  out  7  cursor column

Behaviour:
- Reset is synchronous: clrn low at a rising edge resets the block. It applies in any state, including mid-clear.
  - Reset values: top_row=0, cur_row=0, cur_col=0, wr_en=0, wr_addr=0, wr_data=BLANK, key_ready=0.
  - State after reset is CLR_ALL.
- Handshake:
  - key_ready=1 only in IDLE.
  - A character is accepted on a rising edge with key_valid && key_ready.
  - While key_ready=0, the source must hold key_valid and key_ascii stable. There is no internal buffering.
- phys(r) = (top_row + r) mod ROWS, computed with a compare-and-subtract. Never use a raw 5-bit wrap.
- States: IDLE, PUT, CLR_LINE, CLR_ALL.
- IDLE, on accept, decode key_ascii:
  - 0x20..0x7E: go to PUT. In that cycle wr_en=1, wr_addr={phys(cur_row),cur_col}, wr_data=key_ascii. Then advance the cursor (see below).
  - 0x0D or 0x0A: newline, no write.
  - 0x08 backspace:
    - If cur_col>0: cur_col-1.
    - Else if cur_row>0: cur_row-1, cur_col=COLS-1.
    - Else (0,0): ignore, stay IDLE, no write.
    - When the cursor moved, go to PUT and write BLANK at the new cursor.
  - 0x0C: go to CLR_ALL.
  - Anything else: dropped, stay IDLE.
- Write latency: wr_en asserts exactly one cycle after the accept edge and lasts one cycle.
- Advance after a printable:
  - If cur_col<COLS-1: cur_col+1.
  - Else: cur_col=0 and perform newline.
- Newline:
  - If cur_row<ROWS-1: cur_row+1, cur_col=0, go to IDLE.
  - Else (cur_row=ROWS-1): top_row=phys(1), cur_col=0, cur_row stays ROWS-1, go to CLR_LINE.
- CLR_LINE:
  - Writes BLANK to {old top_row, c} for c=0..COLS-1, one per cycle (COLS cycles).
  - Old top_row is the row now shown at the bottom.
  - Then go to IDLE.
- CLR_ALL:
  - Writes BLANK to every {r,c}, r=0..ROWS-1 and c=0..COLS-1, row-major, one per cycle (ROWS×COLS = 2100 cycles).
  - Then top_row=0, cur_row=0, cur_col=0, go to IDLE.
- wr_addr never carries col≥COLS or row≥ROWS.
- wr_en=0 in IDLE.

Decomposition:
- Shared package (text_term_pkg):
  - Constants: COLS, ROWS, BLANK, ASCII_CR/LF/BS/FF.
  - State enum.
  - Address pack helper {row,col}.
- One natural sub-module: term_row_mod, the combinational (base+offset) mod ROWS adder used for both write and display addressing.
- The clear sweep counter lives inside the main FSM.

Test Plan:
- Reset then idle: clrn low 2 cycles, release → key_ready=0 for 2100 cycles with wr_data=0x20 sweeping 0x000..{29,69} row-major. Then key_ready=1, cursor (0,0), top_row=0.
- Type "AB": send 0x41, 0x42 → writes 0x41@0x000, 0x42@0x001, each 1 cycle after accept. Cursor ends (0,2). key_valid held while busy is taken only once.
- Line wrap: 70 × 0x58 from (0,0) → last write @{0,69}, cursor (1,0), no scroll.
- Scroll: cursor (29,5), top_row=0, send 0x0D → top_row=1, cursor (29,0), 70 writes of 0x20 to {0,0..69}. key_ready low 70 cycles. Next 0x41 writes @{0,0}.
- Backspace: cursor (3,0) → 0x08 gives cursor (2,69) and a 0x20 write @{phys(2),69}. At (0,0) → no write, cursor unchanged.
- Reset mid-scroll: clrn low during CLR_LINE cycle 30 → next cycle state CLR_ALL, top_row=0, cursor (0,0), full 2100-cell clear restarts.
